// File: rtl/uart_tx_sequencer_pkg.sv
`timescale 1ns/1ps
// Shared UART transmit types, word-length encodings and the parity helper
// (the parity helper is also used by the receive side).
package uart_tx_sequencer_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP,
        TX_STOP2
    } tx_state_t;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    // Stick parity overrides odd/even selection.
    function automatic logic uart_parity(input logic [7:0] data, input logic [1:0] wls,
                                         input logic eps, input logic sp);
        logic [7:0] mask;
        logic       result;
        case (wls)
            WLS_5:   mask = 8'h1F;
            WLS_6:   mask = 8'h3F;
            WLS_7:   mask = 8'h7F;
            WLS_8:   mask = 8'hFF;
            default: mask = 8'hFF;
        endcase
        if (sp)
            result = ~eps;
        else if (eps)
            result = ^(data & mask);
        else
            result = ~^(data & mask);
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_sequencer_if.sv
`timescale 1ns/1ps
// Control, configuration and serial-output bundle of the UART transmit sequencer.
interface uart_tx_sequencer_if;
    logic       clear;
    logic       baudtick;
    logic       start;
    logic [7:0] din;
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       eps;
    logic       sp;
    logic       bc;
    logic       busy;
    logic       finished;
    logic       txd;

    modport master (
        output clear, baudtick, start, din, wls, stb, pen, eps, sp, bc,
        input  busy, finished, txd
    );

    modport slave (
        input  clear, baudtick, start, din, wls, stb, pen, eps, sp, bc,
        output busy, finished, txd
    );
endinterface

// File: rtl/slib_counter.sv
`timescale 1ns/1ps
// Generic up/down counter with synchronous clear and load; clear beats load beats count.
module slib_counter #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             load,
    input  logic             enable,
    input  logic             down,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            q_reg <= '0;
        else if (clear)
            q_reg <= '0;
        else if (load)
            q_reg <= d;
        else if (enable)
            q_reg <= down ? q_reg - 1'b1 : q_reg + 1'b1;
    end

    assign q = q_reg;
endmodule

// File: rtl/uart_tx_sequencer.sv
`timescale 1ns/1ps
// UART transmit bit-timing controller: start, 5-8 data bits LSB first, optional parity,
// then 1 / 1.5 / 2 stop bits, each bit measured in oversampling ticks.
module uart_tx_sequencer
    import uart_tx_sequencer_pkg::*;
#(
    parameter int OVS_WIDTH = 4
) (
    input  logic CLK,
    input  logic RST,
    uart_tx_sequencer_if.slave bus
);
    localparam logic [OVS_WIDTH-1:0] Q_FULL = '1;
    localparam logic [OVS_WIDTH-1:0] Q_HALF = Q_FULL >> 1;

    tx_state_t            state_reg, state_next;
    logic [7:0]           shift_reg, shift_next;
    logic [2:0]           bit_idx_reg, bit_idx_next;
    logic [1:0]           wls_reg, wls_next;
    logic                 stb_reg, stb_next;
    logic                 pen_reg, pen_next;
    logic                 parity_reg, parity_next;
    logic                 txd_reg, txd_next;
    logic                 finished_reg, finished_next;
    logic                 txd_value;
    logic                 cnt_clear;
    logic [OVS_WIDTH-1:0] cnt_q;
    logic                 bit_end;
    logic                 stop2_end;

    slib_counter #(.WIDTH(OVS_WIDTH)) u_tick_counter (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (cnt_clear),
        .load   (1'b0),
        .enable (bus.baudtick),
        .down   (1'b0),
        .d      ({OVS_WIDTH{1'b0}}),
        .q      (cnt_q)
    );

    assign bit_end   = bus.baudtick && (cnt_q == Q_FULL);
    // With a 5-bit word the second stop half-bit gives 1.5 stop bits in total.
    assign stop2_end = bus.baudtick && (cnt_q == ((wls_reg == WLS_5) ? Q_HALF : Q_FULL));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= TX_IDLE;
            shift_reg    <= '0;
            bit_idx_reg  <= '0;
            wls_reg      <= '0;
            stb_reg      <= 1'b0;
            pen_reg      <= 1'b0;
            parity_reg   <= 1'b0;
            txd_reg      <= 1'b1;
            finished_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_idx_reg  <= bit_idx_next;
            wls_reg      <= wls_next;
            stb_reg      <= stb_next;
            pen_reg      <= pen_next;
            parity_reg   <= parity_next;
            txd_reg      <= txd_next;
            finished_reg <= finished_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_idx_next  = bit_idx_reg;
        wls_next      = wls_reg;
        stb_next      = stb_reg;
        pen_next      = pen_reg;
        parity_next   = parity_reg;
        finished_next = 1'b0;
        txd_value     = 1'b1;

        case (state_reg)
            TX_IDLE: begin
                if (bus.start) begin
                    state_next   = TX_START;
                    shift_next   = bus.din;
                    bit_idx_next = '0;
                    wls_next     = bus.wls;
                    stb_next     = bus.stb;
                    pen_next     = bus.pen;
                    parity_next  = uart_parity(bus.din, bus.wls, bus.eps, bus.sp);
                end
            end
            TX_START: begin
                if (bit_end)
                    state_next = TX_DATA;
            end
            TX_DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_idx_reg == 3'd4 + {1'b0, wls_reg})
                        state_next = pen_reg ? TX_PARITY : TX_STOP;
                    else
                        bit_idx_next = bit_idx_reg + 3'd1;
                end
            end
            TX_PARITY: begin
                if (bit_end)
                    state_next = TX_STOP;
            end
            TX_STOP: begin
                if (bit_end) begin
                    state_next    = stb_reg ? TX_STOP2 : TX_IDLE;
                    finished_next = ~stb_reg;
                end
            end
            TX_STOP2: begin
                if (stop2_end) begin
                    state_next    = TX_IDLE;
                    finished_next = 1'b1;
                end
            end
            default: state_next = TX_IDLE;
        endcase

        // Abort wins over everything, including a pending START and the end-of-frame pulse.
        if (bus.clear) begin
            state_next    = TX_IDLE;
            finished_next = 1'b0;
        end

        case (state_next)
            TX_START:  txd_value = 1'b0;
            TX_DATA:   txd_value = shift_next[0];
            TX_PARITY: txd_value = parity_next;
            default:   txd_value = 1'b1;
        endcase
        txd_next = txd_value & ~bus.bc;
    end

    assign cnt_clear    = (state_reg == TX_IDLE) || (state_next != state_reg) || bus.clear;
    assign bus.txd      = txd_reg;
    assign bus.busy     = (state_reg != TX_IDLE);
    assign bus.finished = finished_reg;
endmodule
